// File: rtl/regfile_pkg.sv
// Shared constants and write-port arbitration for the multiport register file
// and its reservation scoreboard.
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 3;

  typedef enum logic [1:0] {
    WSEL_NONE = 2'd0,
    WSEL_P0   = 2'd1,
    WSEL_P1   = 2'd2
  } wsel_e;

  // Port 1 wins when both write ports target the same register.
  function automatic wsel_e write_sel(input logic hit0, input logic hit1);
    if (hit1) return WSEL_P1;
    if (hit0) return WSEL_P0;
    return WSEL_NONE;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set by accepted reservations, cleared by writes.
// Exposes busy flags for the read addresses and the WAW stall signal res_ready.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clock_enable,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic              res_valid,
  input  logic [ADDR_W-1:0] res_addr,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              res_ready,
  output logic              busy1,
  output logic              busy2
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_nxt;
  logic             res_accept;

  // Stall depends only on registered state, never on the write ports.
  assign res_ready  = ~pending[res_addr];
  assign res_accept = res_valid & res_ready;
  assign busy1      = pending[raddr1];
  assign busy2      = pending[raddr2];

  always_comb begin
    // NOTE: default first so every path assigns pending_nxt and no latch is inferred.
    pending_nxt = pending;
    for (int i = 0; i < DEPTH; i++) begin
      if (ZERO_REG != 0 && i == 0) begin
        pending_nxt[i] = 1'b0;
      end else if (res_accept && res_addr == ADDR_W'(i)) begin
        pending_nxt[i] = 1'b1;
      end else if ((we0 && waddr0 == ADDR_W'(i)) || (we1 && waddr1 == ADDR_W'(i))) begin
        pending_nxt[i] = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (clock_enable) begin
      pending <= pending_nxt;
    end
  end

endmodule

// File: rtl/multiport_regfile.sv
// Two-write, two-read register file with same-cycle write bypass, optional
// hardwired-zero register 0 and a reservation scoreboard.
module multiport_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clock_enable,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy1,
  output logic              busy2,
  input  logic              res_valid,
  input  logic [ADDR_W-1:0] res_addr,
  output logic              res_ready
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];
  logic              bypass_en;

  // NOTE: the array is flops, not a RAM macro, so every entry gets the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (clock_enable) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!(ZERO_REG != 0 && i == 0)) begin
          case (write_sel(we0 && waddr0 == ADDR_W'(i), we1 && waddr1 == ADDR_W'(i)))
            WSEL_P1: regs[i] <= wdata1;
            WSEL_P0: regs[i] <= wdata0;
            default: ;
          endcase
        end
      end
    end
  end

  // Forwarding is suppressed in reset so the read ports show the cleared array.
  assign bypass_en = (BYPASS != 0) && clock_enable && rst_n;
  assign raddr[0]  = raddr1;
  assign raddr[1]  = raddr2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = regs[raddr[p]];
      if (bypass_en) begin
        case (write_sel(we0 && waddr0 == raddr[p], we1 && waddr1 == raddr[p]))
          WSEL_P1: rdata[p] = wdata1;
          WSEL_P0: rdata[p] = wdata0;
          default: ;
        endcase
      end
      if (ZERO_REG != 0 && raddr[p] == '0) rdata[p] = '0;
    end
  end

  assign rdata1 = rdata[0];
  assign rdata2 = rdata[1];

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .clock_enable(clock_enable),
    .we0         (we0),
    .we1         (we1),
    .waddr0      (waddr0),
    .waddr1      (waddr1),
    .res_valid   (res_valid),
    .res_addr    (res_addr),
    .raddr1      (raddr1),
    .raddr2      (raddr2),
    .res_ready   (res_ready),
    .busy1       (busy1),
    .busy2       (busy2)
  );

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed bench: three register-file configurations share one stimulus stream
// (default, ZERO_REG=1, BYPASS=0); expected values are hand-computed constants.
module tb_multiport_regfile;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clock_enable;
  logic          we0, we1;
  logic [AW-1:0] waddr0, waddr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [AW-1:0] raddr1, raddr2;
  logic          res_valid;
  logic [AW-1:0] res_addr;

  logic [DW-1:0] rdata1, rdata2, z_rdata1, z_rdata2, n_rdata1, n_rdata2;
  logic          busy1, busy2, z_busy1, z_busy2, n_busy1, n_busy2;
  logic          res_ready, z_res_ready, n_res_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multiport_regfile #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .clock_enable(clock_enable),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .busy1(busy1), .busy2(busy2),
    .res_valid(res_valid), .res_addr(res_addr), .res_ready(res_ready)
  );

  multiport_regfile #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .clock_enable(clock_enable),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(z_rdata1), .rdata2(z_rdata2), .busy1(z_busy1), .busy2(z_busy2),
    .res_valid(res_valid), .res_addr(res_addr), .res_ready(z_res_ready)
  );

  multiport_regfile #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .clock_enable(clock_enable),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(n_rdata1), .rdata2(n_rdata2), .busy1(n_busy1), .busy2(n_busy2),
    .res_valid(res_valid), .res_addr(res_addr), .res_ready(n_res_ready)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, far from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; res_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clock_enable = 1'b1;
    we0 = 1'b0; we1 = 1'b0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    raddr1 = 3'd3; raddr2 = 3'd5; res_valid = 1'b0; res_addr = 3'd3;
    #12;
    check("rst_rdata1", rdata1, 16'h0000);
    check("rst_busy1", {15'b0, busy1}, 16'h0001 & 16'h0000);
    check("rst_res_ready", {15'b0, res_ready}, 16'h0001);
    rst_n = 1'b1;

    // Port 0 write to r3 with same-cycle bypass.
    we0 = 1'b1; waddr0 = 3'd3; wdata0 = 16'h1234; raddr1 = 3'd3;
    #1;
    check("byp_r3", rdata1, 16'h1234);
    check("nobyp_r3_old", n_rdata1, 16'h0000);
    tick(); idle(); #1;
    check("stored_r3", rdata1, 16'h1234);
    check("nobyp_r3_new", n_rdata1, 16'h1234);

    // Both ports write r5: port 1 wins in bypass and in storage.
    we0 = 1'b1; waddr0 = 3'd5; wdata0 = 16'hAAAA;
    we1 = 1'b1; waddr1 = 3'd5; wdata1 = 16'h5555; raddr2 = 3'd5;
    #1;
    check("byp_r5_prio", rdata2, 16'h5555);
    tick(); idle(); #1;
    check("stored_r5", rdata2, 16'h5555);
    check("nobyp_r5", n_rdata2, 16'h5555);

    // r0: hardwired zero in dut_z, ordinary register in dut.
    we0 = 1'b1; waddr0 = 3'd0; wdata0 = 16'hFFFF;
    res_valid = 1'b1; res_addr = 3'd0; raddr1 = 3'd0;
    #1;
    check("z_r0_byp", z_rdata1, 16'h0000);
    check("z_r0_ready_pre", {15'b0, z_res_ready}, 16'h0001);
    tick(); idle(); #1;
    check("z_r0_rdata", z_rdata1, 16'h0000);
    check("z_r0_busy", {15'b0, z_busy1}, 16'h0000);
    check("z_r0_ready", {15'b0, z_res_ready}, 16'h0001);
    check("d_r0_rdata", rdata1, 16'hFFFF);
    check("d_r0_busy", {15'b0, busy1}, 16'h0001);
    we0 = 1'b1; waddr0 = 3'd0; wdata0 = 16'h0000;
    tick(); idle(); #1;
    check("d_r0_cleared", {15'b0, busy1}, 16'h0000);

    // Reserve r2, second reserve stalls, port 1 write releases it.
    res_valid = 1'b1; res_addr = 3'd2; raddr1 = 3'd2;
    #1;
    check("r2_ready_first", {15'b0, res_ready}, 16'h0001);
    tick(); #1;
    check("r2_ready_second", {15'b0, res_ready}, 16'h0000);
    check("r2_busy", {15'b0, busy1}, 16'h0001);
    res_valid = 1'b0; we1 = 1'b1; waddr1 = 3'd2; wdata1 = 16'h2222;
    #1;
    check("r2_busy_no_byp", {15'b0, busy1}, 16'h0001);
    check("r2_ready_no_comb", {15'b0, res_ready}, 16'h0000);
    tick(); idle(); #1;
    check("r2_busy_clr", {15'b0, busy1}, 16'h0000);
    check("r2_ready_clr", {15'b0, res_ready}, 16'h0001);
    check("r2_data", rdata1, 16'h2222);

    // Reserve and write r4 together: the set wins.
    res_valid = 1'b1; res_addr = 3'd4; we0 = 1'b1; waddr0 = 3'd4; wdata0 = 16'h4444;
    tick(); idle(); raddr1 = 3'd4; #1;
    check("r4_busy", {15'b0, busy1}, 16'h0001);
    check("r4_data", rdata1, 16'h4444);

    // clock_enable=0: write and reservation of r6 are ignored, no bypass.
    clock_enable = 1'b0;
    we0 = 1'b1; waddr0 = 3'd6; wdata0 = 16'h0F0F; res_valid = 1'b1; res_addr = 3'd6;
    raddr2 = 3'd6;
    #1;
    check("ce0_no_byp", rdata2, 16'h0000);
    tick(); #1;
    check("ce0_r6_hold", rdata2, 16'h0000);
    check("ce0_r6_busy", {15'b0, busy2}, 16'h0000);
    idle(); clock_enable = 1'b1;

    // r1 = 0x00FF and pending, then asynchronous reset mid-cycle.
    we0 = 1'b1; waddr0 = 3'd1; wdata0 = 16'h00FF;
    tick(); idle();
    res_valid = 1'b1; res_addr = 3'd1;
    tick(); idle(); raddr1 = 3'd1; #1;
    check("r1_pre_data", rdata1, 16'h00FF);
    check("r1_pre_busy", {15'b0, busy1}, 16'h0001);
    we0 = 1'b1; waddr0 = 3'd7; wdata0 = 16'h7777; raddr2 = 3'd7;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_r1_data", rdata1, 16'h0000);
    check("arst_r1_busy", {15'b0, busy1}, 16'h0000);
    check("arst_ready", {15'b0, res_ready}, 16'h0001);
    check("arst_r7_no_byp", rdata2, 16'h0000);
    tick();
    check("arst_r7_dropped", rdata2, 16'h0000);
    #3;
    rst_n = 1'b1;
    tick(); idle(); #1;
    check("post_rst_r7", rdata2, 16'h7777);
    raddr2 = 3'd5; #1;
    check("post_rst_r5", rdata2, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 Parameter DATA_W, default 16, sets the register data width in bits.
REQ-002 Parameter ADDR_W, default 3, sets the address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 0; 1 makes register 0 a hardwired zero.
REQ-004 Parameter BYPASS, default 1; 1 forwards same-cycle write data to the read ports.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 Port clk, input, 1 bit: rising-edge clock.
REQ-007 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 Port clock_enable, input, 1 bit: state updates only when 1.
REQ-009 Ports we0/we1, input, 1 bit each: write enables.
REQ-010 Ports waddr0/waddr1, input, ADDR_W each: write addresses.
REQ-011 Ports wdata0/wdata1, input, DATA_W each: write data.
REQ-012 Ports raddr1/raddr2, input, ADDR_W each: read addresses.
REQ-013 Ports rdata1/rdata2, output, DATA_W each: combinational read data.
REQ-014 Ports busy1/busy2, output, 1 bit each: pending bit of raddr1/raddr2.
REQ-015 Port res_valid, input, 1 bit: request to reserve res_addr.
REQ-016 Port res_addr, input, ADDR_W: register to reserve.
REQ-017 Port res_ready, output, 1 bit: reservation can be accepted this cycle.

Function
REQ-018 Writes and scoreboard updates SHALL occur on the rising clk edge only when clock_enable=1; with clock_enable=0 all state holds.
REQ-019 Equal waddr0/waddr1 with both enables set: port 1 data SHALL be stored and port 0 data dropped.
REQ-020 Reads SHALL be combinational with zero latency.
REQ-021 With BYPASS=1 and clock_enable=1, a read address matching an active write SHALL return that write's data in the same cycle, port 1 taking priority; with BYPASS=0, reads return the stored value.
REQ-022 With ZERO_REG=1, address 0 SHALL read 0, ignore writes, never become pending, keep busy at 0, and keep res_ready at 1.
REQ-023 The scoreboard SHALL hold one pending bit per register.
REQ-024 res_ready SHALL equal NOT pending[res_addr], taken from registered state only; this WAW stall has no combinational path from the write ports.
REQ-025 A reservation is accepted when res_valid=1, res_ready=1 and clock_enable=1; acceptance sets pending[res_addr] at the next edge.
REQ-026 A write from either port SHALL clear pending[waddr] at the next edge.
REQ-027 An accepted reservation and a write to the same address in the same cycle: the set SHALL win, leaving pending=1.
REQ-028 A write to a non-pending register SHALL be legal and leave pending=0.
REQ-029 busy1/busy2 SHALL reflect registered pending bits and are not bypassed.
REQ-030 Address arithmetic SHALL be exactly ADDR_W wide, with no out-of-range addresses possible.

Reset
REQ-031 While rst_n=0, all registers and all pending bits SHALL be 0 asynchronously; rdata reads 0, busy reads 0 and res_ready reads 1.
REQ-032 Reset asserted mid-operation SHALL discard in-flight writes and reservations; the first update after release occurs on the first rising edge with rst_n=1.

Structure
REQ-033 Package regfile_pkg SHALL hold the default DATA_W/ADDR_W constants and the port-priority write-select function.
REQ-034 The scoreboard SHALL be sub-module regfile_scoreboard, containing the pending vector, res_ready and busy logic; the data array and bypass muxes stay in the top.

Verification
REQ-035 Reset, then write 0x1234 to r3 via port 0 with raddr1=3 and BYPASS=1: rdata1=0x1234 in the same cycle and after the edge.
REQ-036 Both ports write r5, port 0 0xAAAA and port 1 0x5555: r5=0x5555 after the edge.
REQ-037 ZERO_REG=1, write 0xFFFF to r0 and reserve r0: rdata=0, busy=0, res_ready=1.
REQ-038 Reserve r2, then a second reserve of r2 gets res_ready=0; write r2 with port 1 -> busy=0 and res_ready=1 the next cycle.
REQ-039 Reserve r4 and write r4 in the same cycle -> pending[4]=1; with clock_enable=0 a write of 0x0F0F to r6 leaves r6 unchanged.
REQ-040 Assert rst_n=0 mid-sequence with r1=0x00FF and r1 pending -> r1=0 and busy=0 immediately, without a clock edge.
